debug_trace: RTL and testbench

DEBUG_TRACE -- requirements
Module: debug_trace

---
 rtl/debug_pkg.sv | 34 +++
 rtl/debug_trace_buf.sv | 68 ++++++
 rtl/debug_trace.sv | 188 ++++++++++++++++++
 tb/tb_debug_trace.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug/trace block: address regions, trace FSM states
// and the layout of the trace status word.
package debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_t;

    localparam logic [3:0] REGION_PROBE = 4'h0;
    localparam logic [3:0] REGION_RF    = 4'h1;
    localparam logic [3:0] REGION_IMU   = 4'h2;
    localparam logic [3:0] REGION_DMU   = 4'h3;
    localparam logic [3:0] REGION_CSR   = 4'h4;
    localparam logic [3:0] REGION_EXT5  = 4'h5;
    localparam logic [3:0] REGION_EXT6  = 4'h6;
    localparam logic [3:0] REGION_TRACE = 4'h7;

    localparam logic [11:0] STATUS_OFFSET = 12'hFFF;

    // Status word is {state[1:0], wrapped, count}; count width depends on DEPTH.
    localparam int STAT_COUNT_LSB = 0;

    function automatic int stat_wrapped_bit(input int cnt_w);
        return cnt_w;
    endfunction

    function automatic int stat_state_lsb(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/debug_trace_buf.sv
// Circular trace buffer: one write port, oldest-first read port, fill tracking.
module debug_trace_buf #(
    parameter int W     = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic          wrapped
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wrapped_q, wrapped_d;
    logic [AW-1:0] oldest;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        if (clr) begin
            wr_ptr_d  = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q == CW'(DEPTH)) begin
                wrapped_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Contents are deliberately not reset; count=0 hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Once full, the slot about to be overwritten is the oldest entry.
    assign oldest  = wrapped_q ? wr_ptr_q : '0;
    assign rd_data = mem_q[oldest + rd_idx];
    assign count   = count_q;
    assign wrapped = wrapped_q;

endmodule

// File: rtl/debug_trace.sv
// Debug readout and triggered probe trace. Define DEBUG_TRACE_BP_EN to add the
// pc breakpoint / halt logic; otherwise halt is tied low.
//   state   | meaning
//   IDLE    | not tracing
//   ARMED   | sampling into buffer, waiting for trigger
//   CAPTURE | trigger seen, taking post_len more samples
//   DONE    | capture complete, buffer frozen
module debug_trace
    import debug_pkg::*;
#(
    parameter int PROBE_W  = 32,
    parameter int N_PROBES = 96,
    parameter int DEPTH    = 64,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1,
    localparam int ST_W    = CW + 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               chk_addr,
    output logic [PROBE_W-1:0]        chk_data,
    output logic [31:0]               chk_pc,
    input  logic [N_PROBES*PROBE_W-1:0] probes,
    input  logic [31:0]               pc_in,
    input  logic                      sample_en,
    output logic [19:0]               ext_dbg_addr,
    input  logic [31:0]               ext_dbg_data,
    input  logic                      arm,
    input  logic                      disarm,
    input  logic [11:0]               trig_sel,
    input  logic [PROBE_W-1:0]        trig_val,
    input  logic [11:0]               cap_sel,
    input  logic [$clog2(DEPTH)-1:0]  post_len,
    input  logic                      bp_en,
    input  logic [31:0]               bp_pc,
    input  logic                      resume,
    output logic                      halt,
    output logic                      trace_done
);

    function automatic logic [PROBE_W-1:0] pick(input logic [11:0] sel,
                                                input logic [N_PROBES*PROBE_W-1:0] p);
        logic [PROBE_W-1:0] v;
        v = '0;
        for (int k = 0; k < N_PROBES; k++) begin
            if (sel == 12'(k)) v = p[k*PROBE_W +: PROBE_W];
        end
        return v;
    endfunction

    trace_state_t       state_q, state_d;
    logic [AW-1:0]      rem_q, rem_d;
    logic [PROBE_W-1:0] chk_data_q, chk_data_d;
    logic [31:0]        chk_pc_q, chk_pc_d;
    logic               halt_int;
    logic               eff_sample;
    logic               trig_hit;
    logic               buf_clr, buf_wr;
    logic [PROBE_W-1:0] buf_rd_data;
    logic [CW-1:0]      buf_count;
    logic               buf_wrapped;
    logic [3:0]         region;
    logic [11:0]        offset;
    logic [ST_W-1:0]    status;
    logic               unused_in;

`ifdef DEBUG_TRACE_BP_EN
    logic halt_q, halt_d;

    // A match in the same cycle as resume keeps halt set.
    always_comb begin
        halt_d = halt_q & ~resume;
        if (bp_en && sample_en && (pc_in == bp_pc)) halt_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) halt_q <= 1'b0;
        else     halt_q <= halt_d;
    end

    assign halt_int  = halt_q;
    assign unused_in = ^chk_addr[31:20];
`else
    assign halt_int  = 1'b0;
    assign unused_in = ^{chk_addr[31:20], bp_en, bp_pc, resume};
`endif

    assign eff_sample = sample_en & ~halt_int;
    assign trig_hit   = (pick(trig_sel, probes) == trig_val);

    // disarm beats arm; arm beats any same-cycle trigger or write.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        buf_clr = 1'b0;
        buf_wr  = 1'b0;
        if (disarm) begin
            state_d = ST_IDLE;
        end else if (arm) begin
            state_d = ST_ARMED;
            buf_clr = 1'b1;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (eff_sample) begin
                        buf_wr = 1'b1;
                        if (trig_hit) begin
                            if (post_len == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_CAPTURE;
                                rem_d   = post_len;
                            end
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (eff_sample) begin
                        buf_wr = 1'b1;
                        rem_d  = rem_q - 1'b1;
                        if (rem_q == AW'(1)) state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    debug_trace_buf #(.W(PROBE_W), .DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (pick(cap_sel, probes)),
        .rd_idx  (offset[AW-1:0]),
        .rd_data (buf_rd_data),
        .count   (buf_count),
        .wrapped (buf_wrapped)
    );

    assign region = chk_addr[19:16];
    assign offset = chk_addr[11:0];

    always_comb begin
        status = '0;
        status[STAT_COUNT_LSB +: CW]   = buf_count;
        status[stat_wrapped_bit(CW)]   = buf_wrapped;
        status[stat_state_lsb(CW) +: 2] = state_q;
    end

    always_comb begin
        chk_data_d = '0;
        chk_pc_d   = pc_in;
        case (region)
            REGION_PROBE: chk_data_d = pick(offset, probes);
            REGION_RF, REGION_IMU, REGION_DMU, REGION_CSR, REGION_EXT5, REGION_EXT6:
                chk_data_d = PROBE_W'(ext_dbg_data);
            REGION_TRACE: begin
                if (offset == STATUS_OFFSET)
                    chk_data_d = PROBE_W'(status);
                else if (32'(offset) < 32'(buf_count))
                    chk_data_d = buf_rd_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            chk_data_q <= '0;
            chk_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            chk_data_q <= chk_data_d;
            chk_pc_q   <= chk_pc_d;
        end
    end

    assign chk_data     = chk_data_q;
    assign chk_pc       = chk_pc_q;
    assign ext_dbg_addr = chk_addr[19:0];
    assign halt         = halt_int;
    assign trace_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_trace.sv
// Directed self-checking bench for debug_trace (DEPTH=8 to exercise wraparound).
module tb_debug_trace;

    localparam int PW = 32;
    localparam int NP = 96;
    localparam int DP = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       chk_addr;
    logic [PW-1:0]     chk_data;
    logic [31:0]       chk_pc;
    logic [NP*PW-1:0]  probes;
    logic [31:0]       pc_in;
    logic              sample_en;
    logic [19:0]       ext_dbg_addr;
    logic [31:0]       ext_dbg_data;
    logic              arm, disarm;
    logic [11:0]       trig_sel, cap_sel;
    logic [PW-1:0]     trig_val;
    logic [2:0]        post_len;
    logic              bp_en;
    logic [31:0]       bp_pc;
    logic              resume;
    logic              halt;
    logic              trace_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debug_trace #(.PROBE_W(PW), .N_PROBES(NP), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .chk_addr(chk_addr), .chk_data(chk_data), .chk_pc(chk_pc),
        .probes(probes), .pc_in(pc_in), .sample_en(sample_en), .ext_dbg_addr(ext_dbg_addr),
        .ext_dbg_data(ext_dbg_data), .arm(arm), .disarm(disarm), .trig_sel(trig_sel),
        .trig_val(trig_val), .cap_sel(cap_sel), .post_len(post_len), .bp_en(bp_en),
        .bp_pc(bp_pc), .resume(resume), .halt(halt), .trace_done(trace_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        probes[5*PW +: PW] = 32'hDEADBEEF;
        chk_addr = 32'h0000_0005;
        pc_in = 32'h1111_2222;
        step();
        step();
        checks++; if (chk_data !== 32'h0) begin errors++; $display("FAIL reset_chk_data: got %h expected %h", chk_data, 32'h0); end
        checks++; if (chk_pc !== 32'h0) begin errors++; $display("FAIL reset_chk_pc: got %h expected %h", chk_pc, 32'h0); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", halt); end
        checks++; if (trace_done !== 1'b0) begin errors++; $display("FAIL reset_trace_done: got %b expected 0", trace_done); end
        rst = 1'b0;
        chk_addr = 32'h0007_0FFF;
        step();
        checks++; if (chk_data !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected %h", chk_data, 32'h0); end
    endtask

    task automatic test_readout();
        pc_in = 32'h0000_1234;
        chk_addr = 32'h0000_0005;
        step();
        checks++; if (chk_pc !== 32'h0000_1234) begin errors++; $display("FAIL chk_pc_a: got %h expected %h", chk_pc, 32'h0000_1234); end
        checks++; if (chk_data !== 32'hDEADBEEF) begin errors++; $display("FAIL probe5: got %h expected %h", chk_data, 32'hDEADBEEF); end
        pc_in = 32'hABCD_0000;
        chk_addr = 32'h0000_0FFF;
        step();
        checks++; if (chk_pc !== 32'hABCD_0000) begin errors++; $display("FAIL chk_pc_b: got %h expected %h", chk_pc, 32'hABCD_0000); end
        checks++; if (chk_data !== 32'h0) begin errors++; $display("FAIL probe_oob: got %h expected %h", chk_data, 32'h0); end
        probes[95*PW +: PW] = 32'h9595_9595;
        chk_addr = 32'h0000_005F;
        step();
        checks++; if (chk_data !== 32'h9595_9595) begin errors++; $display("FAIL probe95: got %h expected %h", chk_data, 32'h9595_9595); end
        ext_dbg_data = 32'hCAFE_F00D;
        chk_addr = 32'h0003_0123;
        #1;
        checks++; if (ext_dbg_addr !== 20'h3_0123) begin errors++; $display("FAIL ext_addr: got %h expected %h", ext_dbg_addr, 20'h3_0123); end
        step();
        checks++; if (chk_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL ext_region: got %h expected %h", chk_data, 32'hCAFE_F00D); end
        chk_addr = 32'h0008_0005;
        step();
        checks++; if (chk_data !== 32'h0) begin errors++; $display("FAIL region8: got %h expected %h", chk_data, 32'h0); end
    endtask

    task automatic test_trigger_window();
        int done_at;
        done_at = 0;
        trig_sel = 12'd0; cap_sel = 12'd0; trig_val = 32'd10; post_len = 3'd2;
        probes[0 +: PW] = 32'd0;
        sample_en = 1'b0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int v = 1; v <= 20; v++) begin
            probes[0 +: PW] = PW'(v);
            sample_en = 1'b1;
            step();
            if (trace_done === 1'b1) begin
                done_at = v;
                break;
            end
        end
        sample_en = 1'b0;
        checks++; if (done_at !== 12) begin errors++; $display("FAIL window_done_at: got %0d expected %0d", done_at, 12); end
        for (int n = 0; n < 8; n++) begin
            chk_addr = 32'h0007_0000 | 32'(n);
            step();
            checks++; if (chk_data !== 32'(5 + n)) begin errors++; $display("FAIL window_entry%0d: got %h expected %h", n, chk_data, 32'(5 + n)); end
        end
        chk_addr = 32'h0007_0008;
        step();
        checks++; if (chk_data !== 32'h0) begin errors++; $display("FAIL window_beyond_count: got %h expected %h", chk_data, 32'h0); end
        chk_addr = 32'h0007_0FFF;
        step();
        checks++; if (chk_data !== 32'h78) begin errors++; $display("FAIL window_status: got %h expected %h", chk_data, 32'h78); end
    endtask

    task automatic test_arm_disarm_collision();
        rst = 1'b1;
        step();
        rst = 1'b0;
        arm = 1'b1; disarm = 1'b1;
        step();
        arm = 1'b0; disarm = 1'b0;
        chk_addr = 32'h0007_0FFF;
        step();
        checks++; if (chk_data !== 32'h0) begin errors++; $display("FAIL collision_status: got %h expected %h", chk_data, 32'h0); end
        checks++; if (trace_done !== 1'b0) begin errors++; $display("FAIL collision_done: got %b expected 0", trace_done); end
    endtask

    task automatic test_trigger_before_arm_and_mid_reset();
        trig_sel = 12'd0; cap_sel = 12'd0; trig_val = 32'd10;
        probes[0 +: PW] = 32'd10;
        sample_en = 1'b1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        probes[0 +: PW] = 32'd3;
        step(); step(); step();
        sample_en = 1'b0;
        chk_addr = 32'h0007_0FFF;
        step();
        checks++; if (chk_data !== 32'h23) begin errors++; $display("FAIL pre_arm_trigger_status: got %h expected %h", chk_data, 32'h23); end
        trig_val = 32'd3; post_len = 3'd5;
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        step();
        checks++; if (chk_data !== 32'h44) begin errors++; $display("FAIL capture_status: got %h expected %h", chk_data, 32'h44); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++; if (chk_data !== 32'h0) begin errors++; $display("FAIL mid_capture_reset_status: got %h expected %h", chk_data, 32'h0); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL mid_capture_reset_halt: got %b expected 0", halt); end
    endtask

    task automatic test_post_len_zero_and_rearm();
        probes[0 +: PW] = 32'd7; trig_val = 32'd7; post_len = 3'd0;
        sample_en = 1'b0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        checks++; if (trace_done !== 1'b1) begin errors++; $display("FAIL postlen0_done: got %b expected 1", trace_done); end
        chk_addr = 32'h0007_0FFF;
        step();
        checks++; if (chk_data !== 32'h61) begin errors++; $display("FAIL postlen0_status: got %h expected %h", chk_data, 32'h61); end
        chk_addr = 32'h0007_0000;
        step();
        checks++; if (chk_data !== 32'd7) begin errors++; $display("FAIL postlen0_entry: got %h expected %h", chk_data, 32'd7); end
        trig_val = 32'd99;
        arm = 1'b1;
        step();
        arm = 1'b0;
        probes[0 +: PW] = 32'd20;
        sample_en = 1'b1;
        step(); step();
        arm = 1'b1;
        step();
        arm = 1'b0;
        probes[0 +: PW] = 32'd21;
        step();
        sample_en = 1'b0;
        chk_addr = 32'h0007_0FFF;
        step();
        checks++; if (chk_data !== 32'h21) begin errors++; $display("FAIL rearm_status: got %h expected %h", chk_data, 32'h21); end
        chk_addr = 32'h0007_0000;
        step();
        checks++; if (chk_data !== 32'd21) begin errors++; $display("FAIL rearm_entry: got %h expected %h", chk_data, 32'd21); end
        disarm = 1'b1;
        step();
        disarm = 1'b0;
        chk_addr = 32'h0007_0FFF;
        step();
        checks++; if (chk_data !== 32'h01) begin errors++; $display("FAIL disarm_status: got %h expected %h", chk_data, 32'h01); end
    endtask

    task automatic test_breakpoint();
        bp_en = 1'b1; bp_pc = 32'h8000_0010;
        trig_sel = 12'd0; trig_val = 32'hFFFF_FFFF;
        probes[0 +: PW] = 32'd1;
`ifdef DEBUG_TRACE_BP_EN
        arm = 1'b1;
        step();
        arm = 1'b0;
        sample_en = 1'b1;
        pc_in = 32'h8000_0000;
        step();
        pc_in = 32'h8000_0010;
        step();
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL bp_halt_rise: got %b expected 1", halt); end
        pc_in = 32'h8000_0014;
        step(); step();
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL bp_halt_hold: got %b expected 1", halt); end
        pc_in = 32'h8000_0010; resume = 1'b1;
        step();
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL bp_resume_collision: got %b expected 1", halt); end
        pc_in = 32'h8000_0020;
        step();
        resume = 1'b0;
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL bp_resume: got %b expected 0", halt); end
        sample_en = 1'b0;
        chk_addr = 32'h0007_0FFF;
        step();
        checks++; if (chk_data !== 32'h22) begin errors++; $display("FAIL bp_frozen_count: got %h expected %h", chk_data, 32'h22); end
`else
        sample_en = 1'b1;
        pc_in = 32'h8000_0010;
        step();
        sample_en = 1'b0;
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL bp_disabled_halt: got %b expected 0", halt); end
`endif
        bp_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; chk_addr = '0; probes = '0; pc_in = '0; sample_en = 1'b0;
        ext_dbg_data = '0; arm = 1'b0; disarm = 1'b0; trig_sel = '0; trig_val = '0;
        cap_sel = '0; post_len = '0; bp_en = 1'b0; bp_pc = '0; resume = 1'b0;
        test_reset();
        test_readout();
        test_trigger_window();
        test_arm_disarm_collision();
        test_trigger_before_arm_and_mid_reset();
        test_post_len_zero_and_rearm();
        test_breakpoint();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
